centering_datapath_unit: RTL and testbench

- Datapath that responds to the centering controller's phase enables (En_SUM, En_DIV, En_SUB) and performs mean removal on one block of N samples held in a sample RAM.
- Accumulates all samples, divides by N (arithmetic shift), then writes each sample minus the mean back through the RAM write port.
- Sits between the centering controller and the sample RAM in the whitening front end.

---
 rtl/centering_datapath_unit.sv | 139 +++++++++++++
 tb/tb_centering_datapath_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/centering_datapath_unit.sv
// centering_datapath_unit
//
// Mean-removal datapath for one block of N_SAMPLES samples held in a sample
// RAM. Driven by the centering controller's phase enables:
//   En_SUM : stream every sample out of the RAM and accumulate it
//   En_DIV : one cycle; mean = floor(sum / N_SAMPLES) by arithmetic shift
//   En_SUB : stream every sample again and write back (sample - mean)
// If several enables are high, En_SUM > En_DIV > En_SUB.
//
// Ports
//   CLK_cen, RST_cen        clock, synchronous active-high reset
//   En_SUM, En_DIV, En_SUB  phase enables from the controller
//   rd_en, rd_addr          RAM read request (data returns one cycle later)
//   rd_data                 RAM read data
//   wr_en, wr_addr, wr_data centered sample write-back
//   mean                    registered block mean
//   CEN_Done                one-cycle pulse after the last write of a block
//
// Build option
//   CEN_SAT_EN  defined: wr_data saturates when (rd_data - mean) overflows.
//               undefined: wr_data wraps (two's complement).
module centering_datapath_unit #(
    parameter int DATA_W    = 16,
    parameter int N_SAMPLES = 128,
    parameter int ADDR_W    = 7,
    parameter int ACC_W     = DATA_W + ADDR_W
) (
    input  logic              CLK_cen,
    input  logic              RST_cen,
    input  logic              En_SUM,
    input  logic              En_DIV,
    input  logic              En_SUB,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] mean,
    output logic              CEN_Done
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

    // Floor division by N_SAMPLES: arithmetic shift rounds toward -inf.
    function automatic logic signed [DATA_W-1:0] floor_mean(input logic signed [ACC_W-1:0] a);
        floor_mean = DATA_W'(a >>> ADDR_W);
    endfunction

    logic w_do_sum;
    logic w_do_div;
    logic w_do_sub;

    logic [ADDR_W-1:0]        r_addr_cnt_p0;
    logic                     r_vld_sum_p1;
    logic                     r_vld_sub_p1;
    logic                     r_last_p1;
    logic [ADDR_W-1:0]        r_sub_addr_p1;
    logic signed [ACC_W-1:0]  r_acc_p1;
    logic signed [DATA_W-1:0] r_mean;
    logic                     r_done_p2;

    logic signed [DATA_W-1:0] w_rd_s;
    logic signed [ACC_W-1:0]  w_rd_ext;
    logic signed [ACC_W-1:0]  w_acc_total;
    logic signed [DATA_W-1:0] w_centered;

    assign w_do_sum = En_SUM;
    assign w_do_div = !En_SUM && En_DIV;
    assign w_do_sub = !En_SUM && !En_DIV && En_SUB;

    assign w_rd_s   = rd_data;
    assign w_rd_ext = ACC_W'(w_rd_s);

    // The last SUM read may still be in flight during the DIV cycle, so the
    // mean is taken from the accumulator plus that pending sample.
    assign w_acc_total = r_acc_p1 + (r_vld_sum_p1 ? w_rd_ext : ACC_W'(0));

`ifdef CEN_SAT_EN
    function automatic logic signed [DATA_W-1:0] sat_narrow(input logic signed [DATA_W:0] d);
        if (d[DATA_W] != d[DATA_W-1])
            sat_narrow = d[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            sat_narrow = d[DATA_W-1:0];
    endfunction

    logic signed [DATA_W:0] w_diff;
    assign w_diff     = (DATA_W+1)'(w_rd_s) - (DATA_W+1)'(r_mean);
    assign w_centered = sat_narrow(w_diff);
`else
    // The low DATA_W bits of the widened difference equal the narrow wrapped
    // difference, so no extra guard bit is carried.
    assign w_centered = w_rd_s - r_mean;
`endif

    always_ff @(posedge CLK_cen) begin
        if (RST_cen) begin
            r_addr_cnt_p0 <= '0;
            r_vld_sum_p1  <= 1'b0;
            r_vld_sub_p1  <= 1'b0;
            r_last_p1     <= 1'b0;
            r_sub_addr_p1 <= '0;
            r_acc_p1      <= '0;
            r_mean        <= '0;
            r_done_p2     <= 1'b0;
        end else begin
            // p0 -> p1: read issued this cycle, data returns next cycle
            r_vld_sum_p1 <= w_do_sum;
            r_vld_sub_p1 <= w_do_sub;
            r_last_p1    <= w_do_sub && (r_addr_cnt_p0 == LAST_ADDR);
            if (w_do_sub)
                r_sub_addr_p1 <= r_addr_cnt_p0;

            if (w_do_sum || w_do_sub)
                r_addr_cnt_p0 <= r_addr_cnt_p0 + ADDR_W'(1);
            else if (w_do_div)
                r_addr_cnt_p0 <= '0;

            if (w_do_div) begin
                r_acc_p1 <= '0;
                r_mean   <= floor_mean(w_acc_total);
            end else if (r_vld_sum_p1) begin
                r_acc_p1 <= w_acc_total;
            end

            // p1 -> p2: final write of the block seen, pulse done next cycle
            r_done_p2 <= r_vld_sub_p1 && r_last_p1;
        end
    end

    // Reset overrides the enables in the very cycle it is asserted.
    assign rd_en    = !RST_cen && (w_do_sum || w_do_sub);
    assign rd_addr  = RST_cen ? '0 : r_addr_cnt_p0;
    assign wr_en    = r_vld_sub_p1;
    assign wr_addr  = r_sub_addr_p1;
    assign wr_data  = r_vld_sub_p1 ? w_centered : '0;
    assign mean     = r_mean;
    assign CEN_Done = r_done_p2;

endmodule

// File: tb/tb_centering_datapath_unit.sv
module tb_centering_datapath_unit;
    localparam int DW = 16;
    localparam int N  = 128;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst;
    logic en_sum, en_div, en_sub;
    logic rd_en, wr_en, done;
    logic [AW-1:0] rd_addr, wr_addr;
    logic signed [DW-1:0] rd_data = '0;
    logic signed [DW-1:0] wr_data, mean;

    always #5 clk = ~clk;

    centering_datapath_unit #(.DATA_W(DW), .N_SAMPLES(N), .ADDR_W(AW), .ACC_W(DW+AW)) dut (
        .CLK_cen(clk), .RST_cen(rst),
        .En_SUM(en_sum), .En_DIV(en_div), .En_SUB(en_sub),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mean(mean), .CEN_Done(done)
    );

    // Sample RAM: registered read, one-cycle latency; simple write port.
    logic signed [DW-1:0] mem [N];
    longint samp [N];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     wa_q[$];
    longint wd_q[$];
    int     wc_q[$];
    int     dc_q[$];
    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(int'(wr_addr));
            wd_q.push_back(longint'(wr_data));
            wc_q.push_back(cyc);
        end
        if (done) dc_q.push_back(cyc);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: mean is floor(sum / N) over the first cnt samples.
    function automatic longint model_mean(input int cnt);
        longint s = 0;
        for (int i = 0; i < cnt; i++) s += samp[i];
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

`ifdef CEN_SAT_EN
    function automatic longint model_out(input longint s, input longint m);
        longint d = s - m;
        if (d > 32767) return 32767;
        if (d < -32768) return -32768;
        return d;
    endfunction
`else
    function automatic longint model_out(input longint s, input longint m);
        logic signed [DW-1:0] t;
        t = DW'(s - m);
        return longint'(t);
    endfunction
`endif

    task automatic load(input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0: samp[i] = 5;
                1: samp[i] = i;
                2: samp[i] = (i % 2) ? -1 : 0;
                3: samp[i] = (i < 64) ? 32767 : -32768;
                4: samp[i] = -3;
                default: begin
                    case ($urandom_range(0, 7))
                        0: samp[i] = 32767;
                        1: samp[i] = -32768;
                        default: samp[i] = longint'($urandom_range(0, 65535)) - 32768;
                    endcase
                end
            endcase
            mem[i] = DW'(samp[i]);
        end
    endtask

    task automatic clear_q();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); dc_q.delete();
    endtask

    // Full SUM / DIV / SUB run; starts and ends 1 time unit after a posedge.
    task automatic run_block(input string nm);
        longint em;
        clear_q();
        en_sum = 1'b1;
        repeat (N) @(posedge clk);
        #1 en_sum = 1'b0; en_div = 1'b1;
        @(posedge clk);
        #1 en_div = 1'b0; en_sub = 1'b1;
        repeat (N) @(posedge clk);
        #1 en_sub = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        em = model_mean(N);
        check($sformatf("%s mean", nm), longint'(mean), em);
        check($sformatf("%s write count", nm), wa_q.size(), N);
        if (wa_q.size() == N) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("%s wr_addr[%0d]", nm, i), wa_q[i], i);
                check($sformatf("%s wr_data[%0d]", nm, i), wd_q[i], model_out(samp[i], em));
            end
            check($sformatf("%s write span", nm), wc_q[N-1] - wc_q[0], N - 1);
        end
        check($sformatf("%s done pulses", nm), dc_q.size(), 1);
        if (dc_q.size() >= 1 && wc_q.size() >= 1)
            check($sformatf("%s done latency", nm), dc_q[0] - wc_q[wc_q.size()-1], 1);
    endtask

    typedef struct {
        string  name;
        int     kind;
        longint exp_mean;
        int     pa;
        longint pa_exp;
        int     pb;
        longint pb_exp;
    } vec_t;

    vec_t tbl [5];

    task automatic apply_vec(input int t);
        load(tbl[t].kind);
        run_block(tbl[t].name);
        check($sformatf("%s table mean", tbl[t].name), longint'(mean), tbl[t].exp_mean);
        check($sformatf("%s ram[%0d]", tbl[t].name, tbl[t].pa), longint'(mem[tbl[t].pa]), tbl[t].pa_exp);
        check($sformatf("%s ram[%0d]", tbl[t].name, tbl[t].pb), longint'(mem[tbl[t].pb]), tbl[t].pb_exp);
    endtask

    initial begin
        tbl[0] = '{"const5", 0, 5, 0, 0, 127, 0};
        tbl[1] = '{"ramp", 1, 63, 0, -63, 127, 64};
        tbl[2] = '{"alt0m1", 2, -1, 0, 1, 1, 0};
`ifdef CEN_SAT_EN
        tbl[3] = '{"maxmin", 3, -1, 0, 32767, 64, -32767};
`else
        tbl[3] = '{"maxmin", 3, -1, 0, -32768, 64, -32767};
`endif
        tbl[4] = '{"constm3", 4, -3, 0, 0, 127, 0};

        rst = 1'b1; en_sum = 1'b0; en_div = 1'b0; en_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rd_en", rd_en, 0);
        check("reset rd_addr", rd_addr, 0);
        check("reset wr_en", wr_en, 0);
        check("reset wr_addr", wr_addr, 0);
        check("reset wr_data", wr_data, 0);
        check("reset mean", mean, 0);
        check("reset done", done, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int t = 0; t < 4; t++) apply_vec(t);

        // Reset after 50 SUM cycles, with En_SUM still high across the reset.
        load(5);
        clear_q();
        en_sum = 1'b1;
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstsum rd_en", rd_en, 0);
        check("rstsum wr_en", wr_en, 0);
        check("rstsum mean", mean, 0);
        rst = 1'b0; en_sum = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rstsum writes", wa_q.size(), 0);
        check("rstsum done", dc_q.size(), 0);

        // Reset just before the final SUB read: no write of 127, no done.
        load(5);
        clear_q();
        en_sum = 1'b1;
        repeat (N) @(posedge clk);
        #1 en_sum = 1'b0; en_div = 1'b1;
        @(posedge clk);
        #1 en_div = 1'b0; en_sub = 1'b1;
        repeat (N - 1) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstsub rd_en", rd_en, 0);
        check("rstsub wr_en", wr_en, 0);
        rst = 1'b0; en_sub = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rstsub writes", wa_q.size(), N - 1);
        check("rstsub done", dc_q.size(), 0);
        check("rstsub mean", mean, 0);

        apply_vec(4);

        // En_SUM and En_SUB together: SUM wins, 4 reads, no writes.
        for (int i = 0; i < N; i++) begin
            samp[i] = (i < 4) ? 3200 : 1000;
            mem[i]  = DW'(samp[i]);
        end
        clear_q();
        en_sum = 1'b1; en_sub = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("both rd_en %0d", k), rd_en, 1);
            check($sformatf("both rd_addr %0d", k), rd_addr, k);
            @(posedge clk);
            #1;
        end
        en_sum = 1'b0; en_sub = 1'b0; en_div = 1'b1;
        @(posedge clk);
        #1 en_div = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("both mean", longint'(mean), model_mean(4));
        check("both writes", wa_q.size(), 0);
        check("both done", dc_q.size(), 0);

        for (int r = 0; r < 4; r++) begin
            load(5);
            run_block($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
